// File: rtl/uart_tx_fifo.sv
// CPU-facing UART transmitter: byte FIFO written over the peripheral bus,
// drained by an 8N1 serialiser. Status, overflow and flush are exposed on the bus.
module uart_tx_fifo #(
  parameter int BAUDRATE = 3_000_000,
  parameter int CLKFREQ  = 100_000_000,
  parameter int DEPTH    = 8
) (
  input  logic       clk,
  input  logic       rst_in,
  input  logic       wr,
  input  logic       rd,
  input  logic [1:0] adr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       tx,
  output logic       busy,
  output logic       full,
  output logic [1:0] dbg_state_o
);

  localparam int DIV = CLKFREQ / BAUDRATE;
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      bit_q;
  logic [7:0]      shift_q;
  logic            tx_q;
  logic [7:0]      dout_q;
  logic            ovf_q, ovf_d;
  logic [AW:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [7:0]      mem_q [DEPTH];

  logic empty, full_w, flush, push_req, push, pop, ovf_set, rd_status, baud_done;

  // Bus strobes are single-cycle; there is no back-pressure, so a write to a
  // full FIFO is simply dropped and recorded in the sticky overflow flag.
  assign flush     = wr && (adr == 2'd2) && din[0];
  assign push_req  = wr && (adr == 2'd0);
  assign rd_status = rd && (adr == 2'd1);

  assign empty  = (wptr_q == rptr_q);
  assign full_w = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  assign push    = push_req && !full_w && !flush;
  assign ovf_set = push_req && full_w && !flush;

  assign baud_done = (cnt_q == CW'(DIV - 1));
  assign pop = !empty && !flush &&
               ((state_q == S_IDLE) || ((state_q == S_STOP) && baud_done));

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + (AW+1)'(1);
      if (pop)  rptr_d = rptr_q + (AW+1)'(1);
    end
    ovf_d = (ovf_q && !rd_status) || ovf_set;
  end

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= 1'b0;
      dout_q <= 8'h00;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      ovf_q  <= ovf_d;
      if (rd) dout_q <= rd_status ? {4'b0000, ovf_q, busy, full_w, empty} : 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= din;
  end

  // Baud counter restarts on every state entry, so each bit lasts exactly DIV cycles.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          tx_q  <= 1'b1;
          cnt_q <= '0;
          if (pop) begin
            shift_q <= mem_q[rptr_q[AW-1:0]];
            tx_q    <= 1'b0;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (baud_done) begin
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            tx_q    <= shift_q[0];
            state_q <= S_DATA;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DATA: begin
          if (baud_done) begin
            cnt_q <= '0;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= S_STOP;
            end else begin
              bit_q   <= bit_q + 3'd1;
              shift_q <= shift_q >> 1;
              tx_q    <= shift_q[1];
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_STOP: begin
          if (baud_done) begin
            cnt_q <= '0;
            if (pop) begin
              shift_q <= mem_q[rptr_q[AW-1:0]];
              tx_q    <= 1'b0;
              state_q <= S_START;
            end else begin
              tx_q    <= 1'b1;
              state_q <= S_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          tx_q    <= 1'b1;
          cnt_q   <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy        = (state_q != S_IDLE) || !empty;
  assign full        = full_w;
  assign tx          = tx_q;
  assign dout        = dout_q;
  assign dbg_state_o = state_q;

endmodule
